// File: rtl/cmp_debounce_monitor.sv
// -----------------------------------------------------------------------------
// cmp_debounce_monitor
//
// Debounces the e/g/l flags of an upstream magnitude comparator, where the
// comparator's a input is a streamed sample and its b input is a fixed
// threshold. It produces a debounced above-threshold level, rise/fall event
// pulses, saturating event counters and a sticky illegal-flags error.
//
// Ports:
//   clk       : clock; all state updates on the rising edge
//   rst_n     : asynchronous reset, active low
//   in_valid  : e/g/l carry a sample this cycle
//   e, g, l   : comparator equal / greater / less flags
//   clr       : synchronous clear of rise_cnt, fall_cnt and err
//   above     : debounced level (1 = sample at or above threshold)
//   rise_evt  : one-cycle pulse on a LOW->HIGH transition
//   fall_evt  : one-cycle pulse on a HIGH->LOW transition
//   rise_cnt  : saturating count of rise events
//   fall_cnt  : saturating count of fall events
//   err       : sticky flag, set by a valid sample whose flags are not one-hot
// -----------------------------------------------------------------------------
module cmp_debounce_monitor #(
  parameter int DEB   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             e,
  input  logic             g,
  input  logic             l,
  input  logic             clr,
  output logic             above,
  output logic             rise_evt,
  output logic             fall_evt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             err
);

  localparam int RUN_W = $clog2(DEB + 1);
  localparam logic [RUN_W-1:0] DEB_RUN  = RUN_W'(DEB);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_TO_HIGH,
    ST_HIGH,
    ST_TO_LOW
  } state_t;

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [RUN_W-1:0] run_inc;
  logic             above_next;
  logic             rise_next, fall_next;
  logic             err_next;
  logic             one_hot, hi, sample_ok;

  // Exactly one of e/g/l set; anything else is an illegal comparator output.
  assign one_hot   = (e | g | l) & ~((e & g) | (e & l) | (g & l));
  assign hi        = g | e;
  assign sample_ok = in_valid & one_hot;
  assign run_inc   = run_reg + RUN_ONE;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;

    if (sample_ok) begin
      unique case (state_reg)
        ST_LOW: begin
          if (hi) begin
            if (DEB == 1) begin
              state_next = ST_HIGH;
              rise_next  = 1'b1;
            end else begin
              state_next = ST_TO_HIGH;
              run_next   = RUN_ONE;
            end
          end
        end
        ST_TO_HIGH: begin
          if (hi) begin
            if (run_inc == DEB_RUN) begin
              state_next = ST_HIGH;
              run_next   = '0;
              rise_next  = 1'b1;
            end else begin
              run_next   = run_inc;
            end
          end else begin
            // A single opposing sample breaks the run.
            state_next = ST_LOW;
            run_next   = '0;
          end
        end
        ST_HIGH: begin
          if (!hi) begin
            if (DEB == 1) begin
              state_next = ST_LOW;
              fall_next  = 1'b1;
            end else begin
              state_next = ST_TO_LOW;
              run_next   = RUN_ONE;
            end
          end
        end
        ST_TO_LOW: begin
          if (!hi) begin
            if (run_inc == DEB_RUN) begin
              state_next = ST_LOW;
              run_next   = '0;
              fall_next  = 1'b1;
            end else begin
              run_next   = run_inc;
            end
          end else begin
            state_next = ST_HIGH;
            run_next   = '0;
          end
        end
        default: begin
          state_next = ST_LOW;
          run_next   = '0;
        end
      endcase
    end

    above_next = (state_next == ST_HIGH) || (state_next == ST_TO_LOW);
    // clr wins over the old value, but an illegal sample in the same cycle
    // still leaves err set.
    err_next   = (err & ~clr) | (in_valid & ~one_hot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_LOW;
      run_reg   <= '0;
      above     <= 1'b0;
      rise_evt  <= 1'b0;
      fall_evt  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      above     <= above_next;
      rise_evt  <= rise_next;
      fall_evt  <= fall_next;
      err       <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Event counters: index 0 counts rises, index 1 counts falls.
  // clr zeroes the base first, so an event in the same cycle leaves 1.
  // ---------------------------------------------------------------------------
  logic [1:0]            evt_next;
  logic [CNT_W-1:0]      cnt_reg [2];

  assign evt_next = {fall_next, rise_next};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
      cnt_base = clr ? '0 : cnt_reg[gi];
      cnt_next = cnt_base;
      if (evt_next[gi] && (cnt_base != CNT_MAX)) begin
        cnt_next = cnt_base + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg[gi] <= '0;
      end else begin
        cnt_reg[gi] <= cnt_next;
      end
    end
  end

  assign rise_cnt = cnt_reg[0];
  assign fall_cnt = cnt_reg[1];

endmodule
